multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, giving the maximum consecutive memory-wait cycles before bus error; legal range 0..255, where 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port opcode, input, 7, instruction[6:0] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory access completes in the current cycle.
REQ-006 SHALL have port mem_req, output, 1, memory access request.
REQ-007 SHALL have port mem_we, output, 1, memory write.
REQ-008 SHALL have port adr_src, output, 1, memory address select: 0 = PC, 1 = ALU-out register.
REQ-009 SHALL have outputs ir_write, pc_write and reg_write, each 1 bit, write strobes.
REQ-010 SHALL have output imm_src, 2 bits, immediate format for the sign extender: 00 = I, 01 = S.
REQ-011 SHALL have output alu_src_a, 2 bits: 00 = PC, 01 = old PC, 10 = rs1.
REQ-012 SHALL have output alu_src_b, 2 bits: 00 = rs2, 01 = imm_ext, 10 = constant 4.
REQ-013 SHALL have output alu_op, 2 bits: 00 = add, 10 = funct decode.
REQ-014 SHALL have output result_src, 2 bits: 00 = ALU-out register, 01 = memory data, 10 = ALU result.
REQ-015 SHALL have outputs state (4 bits, debug), bus_error (1 bit) and illegal_instr (1 bit).

Function
REQ-016 SHALL implement the following Moore FSM states and encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, TRAP=9.
REQ-017 SHALL drive every output not listed for the current state to 0.
REQ-018 FETCH SHALL drive mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, and ir_write=pc_write=mem_ready; it SHALL hold until mem_ready=1, then go to DECODE.
REQ-019 DECODE SHALL drive alu_src_a=01, alu_src_b=01, and imm_src=01 if opcode=0100011, else 00.
REQ-020 DECODE SHALL branch on opcode: 0000011 (lw) or 0100011 (sw) -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; any other opcode per REQ-031/032.
REQ-021 MEM_ADR SHALL drive alu_src_a=10, alu_src_b=01, and imm_src=01 for sw, 00 for lw; next state is MEM_WRITE for sw, MEM_READ for lw.
REQ-022 MEM_READ SHALL drive mem_req=1, adr_src=1, and hold until mem_ready, then go to MEM_WB.
REQ-023 MEM_WB SHALL drive result_src=01 and reg_write=1, then go to FETCH.
REQ-024 MEM_WRITE SHALL drive mem_req=1, mem_we=1, adr_src=1, and hold until mem_ready, then go to FETCH.
REQ-025 EXEC_R SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10, then go to ALU_WB.
REQ-026 EXEC_I SHALL drive alu_src_a=10, alu_src_b=01, alu_op=10, imm_src=00, then go to ALU_WB.
REQ-027 ALU_WB SHALL drive result_src=00 and reg_write=1, then go to FETCH.
REQ-028 SHALL maintain an 8-bit wait counter: it increments each cycle in FETCH, MEM_READ or MEM_WRITE while mem_ready=0, and clears on any state change.
REQ-029 If WAIT_LIMIT≠0, counter equals WAIT_LIMIT-1 and mem_ready=0, the block SHALL enter TRAP and set bus_error; if mem_ready=1 in that same cycle, the access SHALL complete normally.
REQ-030 TRAP SHALL hold all strobes at 0 and remain until reset; bus_error and illegal_instr are sticky.

Configuration
REQ-031 With macro MULTICYCLE_ILLEGAL_TRAP_EN defined, an unknown opcode in DECODE SHALL set illegal_instr and go to TRAP.
REQ-032 Without MULTICYCLE_ILLEGAL_TRAP_EN, an unknown opcode SHALL return to FETCH (NOP) and illegal_instr SHALL be tied to 0.

Reset
REQ-033 rst_n=0 SHALL immediately force state=FETCH, clear the wait counter, bus_error and illegal_instr, regardless of the current state.
REQ-034 While rst_n=0, mem_req, mem_we, ir_write, pc_write and reg_write SHALL be 0; normal FETCH outputs begin on the first clock edge after release.

Verification
REQ-035 lw with mem_ready always 1 -> states 0,1,2,3,4,0; imm_src=00 in MEM_ADR; reg_write high exactly 1 cycle.
REQ-036 sw with mem_ready always 1 -> states 0,1,2,5,0; imm_src=01 in DECODE and MEM_ADR; mem_we=1 only in MEM_WRITE.
REQ-037 R-type, mem_ready low for 3 FETCH cycles -> single pc_write/ir_write pulse on the 4th cycle, then states 1,6,8,0.
REQ-038 WAIT_LIMIT=4, mem_ready held 0 in MEM_READ -> state=9 and bus_error=1 after 4 wait cycles; with mem_ready=1 on the 4th cycle -> MEM_WB instead.
REQ-039 opcode 1101111 -> with macro: illegal_instr=1 and state=9; without: state returns to 0 after DECODE.
REQ-040 rst_n pulsed low in MEM_WRITE with mem_ready=0 -> asynchronous state=0, all strobes and flags 0, clean FETCH resumes after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for a multicycle lw/sw/R/I core with memory-wait timeout
// Optional feature: define MULTICYCLE_ILLEGAL_TRAP_EN to trap unknown opcodes (sets illegal_instr).
module multicycle_controller #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [3:0] state,
  output logic       bus_error,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t     state_q, state_n;
  logic [7:0] wait_cnt;
  logic       active;
  logic       bus_error_q;
  logic       waiting;
  logic       timeout;

  // active stays low through reset and the first edge after release so strobes stay quiet
  assign waiting = active && !mem_ready &&
                   (state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE);
  assign timeout = (WAIT_LIMIT != 0) && waiting && (wait_cnt == LIMIT_M1);

  always_comb begin
    state_n    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req    = active;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = active && mem_ready;
        pc_write   = active && mem_ready;
        if (mem_ready)    state_n = S_DECODE;
        else if (timeout) state_n = S_TRAP;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_SW) ? 2'b01 : 2'b00;
        if (opcode == OP_LW || opcode == OP_SW) state_n = S_MEM_ADR;
        else if (opcode == OP_R)                state_n = S_EXEC_R;
        else if (opcode == OP_I)                state_n = S_EXEC_I;
        else
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_n = S_TRAP;
`else
          state_n = S_FETCH;
`endif
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_SW) ? 2'b01 : 2'b00;
        state_n   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_n = S_MEM_WB;
        else if (timeout) state_n = S_TRAP;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_n = S_FETCH;
        else if (timeout) state_n = S_TRAP;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_n   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_n   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_n   = S_FETCH;
      end
      default: state_n = S_TRAP;
    endcase
    if (!active) state_n = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      wait_cnt    <= 8'd0;
      active      <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      active   <= 1'b1;
      state_q  <= state_n;
      wait_cnt <= (state_n != state_q) ? 8'd0 : (waiting ? wait_cnt + 8'd1 : wait_cnt);
      if (timeout) bus_error_q <= 1'b1;
    end
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic illegal_q;
  // the only DECODE -> TRAP path is an unknown opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else if (state_q == S_DECODE && state_n == S_TRAP) illegal_q <= 1'b1;
  end
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  assign state     = state_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller (WAIT_LIMIT=4)
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state;
  logic       bus_error, illegal_instr;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  multicycle_controller #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .state(state),
    .bus_error(bus_error), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench 1 time unit after the first active edge following release, in FETCH
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (state !== 4'd0 || bus_error !== 1'b0 || illegal_instr !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d bus_error=%b illegal=%b required 0/0/0", state, bus_error, illegal_instr);
    end
    checks++;
    if ({mem_req, mem_we, ir_write, pc_write, reg_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 00000", {mem_req, mem_we, ir_write, pc_write, reg_write});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_quiet: mem_req=%b required 0", mem_req);
    end
    tick();
    checks++;
    if (state !== 4'd0 || mem_req !== 1'b1 || alu_src_b !== 2'b10 || result_src !== 2'b10 || ir_write !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_fetch: state=%0d mem_req=%b alu_src_b=%b result_src=%b ir_write=%b required 0/1/10/10/1",
               state, mem_req, alu_src_b, result_src, ir_write);
    end
  endtask

  task automatic test_lw();
    int exp_st[5] = '{1, 2, 3, 4, 0};
    int rw = 0;
    opcode = OP_LW;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      rw += int'(reg_write);
      checks++;
      if (state !== 4'(exp_st[i])) begin
        errors++;
        $display("FAIL lw_state[%0d]: got %0d required %0d", i, state, exp_st[i]);
      end
      if (exp_st[i] == 2) begin
        checks++;
        if (imm_src !== 2'b00 || alu_src_a !== 2'b10) begin
          errors++;
          $display("FAIL lw_mem_adr: imm_src=%b alu_src_a=%b required 00/10", imm_src, alu_src_a);
        end
      end
      if (exp_st[i] == 4) begin
        checks++;
        if (result_src !== 2'b01) begin
          errors++;
          $display("FAIL lw_mem_wb_result_src: got %b required 01", result_src);
        end
      end
    end
    checks++;
    if (rw !== 1) begin
      errors++;
      $display("FAIL lw_reg_write_cycles: got %0d required 1", rw);
    end
  endtask

  task automatic test_sw();
    int exp_st[4] = '{1, 2, 5, 0};
    opcode = OP_SW;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== 4'(exp_st[i])) begin
        errors++;
        $display("FAIL sw_state[%0d]: got %0d required %0d", i, state, exp_st[i]);
      end
      checks++;
      if (mem_we !== (exp_st[i] == 5)) begin
        errors++;
        $display("FAIL sw_mem_we[%0d]: got %b in state %0d", i, mem_we, state);
      end
      if (exp_st[i] == 1 || exp_st[i] == 2) begin
        checks++;
        if (imm_src !== 2'b01) begin
          errors++;
          $display("FAIL sw_imm_src[%0d]: got %b required 01", i, imm_src);
        end
      end
    end
  endtask

  task automatic test_rtype_wait();
    int exp_st[4] = '{1, 6, 8, 0};
    opcode = OP_R;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state !== 4'd0 || pc_write !== 1'b0 || ir_write !== 1'b0 || mem_req !== 1'b1) begin
        errors++;
        $display("FAIL r_fetch_wait[%0d]: state=%0d pc_write=%b ir_write=%b mem_req=%b required 0/0/0/1",
                 i, state, pc_write, ir_write, mem_req);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || pc_write !== 1'b1 || ir_write !== 1'b1) begin
      errors++;
      $display("FAIL r_fetch_pulse: state=%0d pc_write=%b ir_write=%b required 0/1/1", state, pc_write, ir_write);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (state !== 4'(exp_st[i]) || pc_write !== (exp_st[i] == 0)) begin
        errors++;
        $display("FAIL r_state[%0d]: state=%0d pc_write=%b required state %0d", i, state, pc_write, exp_st[i]);
      end
      if (exp_st[i] == 6) begin
        checks++;
        if (alu_op !== 2'b10 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
          errors++;
          $display("FAIL r_exec: alu_op=%b alu_src_a=%b alu_src_b=%b required 10/10/00", alu_op, alu_src_a, alu_src_b);
        end
      end
    end
  endtask

  // brings an lw into MEM_READ with mem_ready low, then waits three cycles (wait count 3)
  task automatic lw_to_read_wait3();
    opcode = OP_LW;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_timeout();
    do_reset();
    lw_to_read_wait3();
    checks++;
    if (state !== 4'd3 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_before_limit: state=%0d bus_error=%b required 3/0", state, bus_error);
    end
    tick();
    checks++;
    if (state !== 4'd9 || bus_error !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_trap: state=%0d bus_error=%b mem_req=%b required 9/1/0", state, bus_error, mem_req);
    end
    mem_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (state !== 4'd9 || bus_error !== 1'b1 || {mem_req, ir_write, pc_write, reg_write} !== 4'b0) begin
      errors++;
      $display("FAIL trap_sticky: state=%0d bus_error=%b strobes=%b required 9/1/0000",
               state, bus_error, {mem_req, ir_write, pc_write, reg_write});
    end
    do_reset();
    checks++;
    if (bus_error !== 1'b0 || state !== 4'd0) begin
      errors++;
      $display("FAIL bus_error_clear: bus_error=%b state=%0d required 0/0", bus_error, state);
    end
    lw_to_read_wait3();
    mem_ready = 1'b1;
    tick();
    checks++;
    if (state !== 4'd4 || bus_error !== 1'b0 || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL timeout_last_cycle_ready: state=%0d bus_error=%b reg_write=%b required 4/0/1", state, bus_error, reg_write);
    end
    tick();
  endtask

  task automatic test_illegal();
    opcode = OP_JAL;
    mem_ready = 1'b1;
    tick();
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL illegal_decode: state=%0d required 1", state);
    end
    tick();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    checks++;
    if (state !== 4'd9 || illegal_instr !== 1'b1 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL illegal_trap: state=%0d illegal=%b bus_error=%b required 9/1/0", state, illegal_instr, bus_error);
    end
    do_reset();
`else
    checks++;
    if (state !== 4'd0 || illegal_instr !== 1'b0) begin
      errors++;
      $display("FAIL illegal_nop: state=%0d illegal=%b required 0/0", state, illegal_instr);
    end
`endif
  endtask

  task automatic test_reset_in_write();
    opcode = OP_SW;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if (state !== 4'd5 || mem_we !== 1'b1 || adr_src !== 1'b1) begin
      errors++;
      $display("FAIL write_wait: state=%0d mem_we=%b adr_src=%b required 5/1/1", state, mem_we, adr_src);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || {mem_req, mem_we, ir_write, pc_write, reg_write} !== 5'b0 ||
        bus_error !== 1'b0 || illegal_instr !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d strobes=%b bus_error=%b illegal=%b required 0/00000/0/0",
               state, {mem_req, mem_we, ir_write, pc_write, reg_write}, bus_error, illegal_instr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || mem_req !== 1'b1 || mem_we !== 1'b0 || ir_write !== 1'b1) begin
      errors++;
      $display("FAIL resume_fetch: state=%0d mem_req=%b mem_we=%b ir_write=%b required 0/1/0/1",
               state, mem_req, mem_we, ir_write);
    end
    tick();
    checks++;
    if (state !== 4'd1) begin
      errors++;
      $display("FAIL resume_decode: state=%0d required 1", state);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype_wait();
    test_timeout();
    test_illegal();
    test_reset_in_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
